// File: rtl/apb_lin_master.sv
// apb_lin_master
// APB3 initiator for the LIN peripheral's APB slave port. It takes
// single-word requests from a local requester, runs the SETUP and ACCESS
// phases, and waits for pready. It then returns read data, or a completion
// with an error flag. Only one transfer is outstanding at a time. A
// programmable wait-state timeout aborts a hung transfer with an error.
//
// Handshake: the requester presents req_i together with we_i, addr_i and
// wdata_i. The request is taken on a rising edge where the block is IDLE,
// and gnt_o pulses on the following cycle. The requester keeps req_i high
// until it sees gnt_o. When the transfer finishes, rvalid_o pulses for one
// cycle; err_o, rdata_o and timeout_o are valid in that cycle.
//
// Ports:
//   pclk, preset_i           clock, asynchronous active-low reset
//   req_i/we_i/addr_i/wdata_i local request
//   gnt_o                     request captured (1-cycle pulse)
//   rvalid_o/rdata_o/err_o    completion (pulse), read data, error flag
//   timeout_o                 completion was a timeout abort (pulse)
//   busy_o                    transfer in SETUP or ACCESS
//   psel_o ... pwdata_o       APB request side
//   prdata_i/pready_i/pslverr_i APB response side
//   dbg_state_o               current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
module apb_lin_master #(
  parameter int addr_width     = 12,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 16
) (
  input  logic                  pclk,
  input  logic                  preset_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] addr_i,
  input  logic [data_width-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [data_width-1:0] rdata_o,
  output logic                  err_o,
  output logic                  timeout_o,
  output logic                  busy_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [addr_width-1:0] paddr_o,
  output logic [data_width-1:0] pwdata_o,
  input  logic [data_width-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int  CW      = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
  localparam bit  TO_EN   = (timeout_cycles > 0);
  // The abort happens on the edge that would bring the count up to
  // timeout_cycles, so it is compared against one less than the limit.
  localparam logic [CW-1:0] TO_LAST = CW'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);

  state_t        state;
  logic [CW-1:0] wait_cnt;

  assign dbg_state_o = state;

  always_ff @(posedge pclk or negedge preset_i) begin
    if (!preset_i) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      gnt_o     <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
      busy_o    <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
    end else begin
      // Pulse outputs default low; each branch raises them for one cycle.
      gnt_o     <= 1'b0;
      rvalid_o  <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            state     <= SETUP;
            paddr_o   <= addr_i;
            pwrite_o  <= we_i;
            pwdata_o  <= we_i ? wdata_i : '0;
            gnt_o     <= 1'b1;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            busy_o    <= 1'b1;
            wait_cnt  <= '0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          // If pready arrives on the threshold edge, the normal completion
          // takes priority over the timeout.
          if (pready_i) begin
            state     <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            busy_o    <= 1'b0;
            rvalid_o  <= 1'b1;
            err_o     <= pslverr_i;
            rdata_o   <= (!pwrite_o && !pslverr_i) ? prdata_i : '0;
            wait_cnt  <= '0;
          end else if (TO_EN && (wait_cnt == TO_LAST)) begin
            state     <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            busy_o    <= 1'b0;
            rvalid_o  <= 1'b1;
            err_o     <= 1'b1;
            timeout_o <= 1'b1;
            rdata_o   <= '0;
            wait_cnt  <= '0;
          end else if (TO_EN) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_lin_master.sv
// Directed testbench for apb_lin_master. Inputs change and outputs are
// sampled on the falling edge of pclk. Each task checks its own scenario.
module tb_apb_lin_master;

  logic        pclk;
  logic        preset_i;
  logic        req_i;
  logic        we_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        timeout_o;
  logic        busy_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [11:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;
  logic [1:0]  dbg_state_o;

  int n_assert = 0;
  int n_fail   = 0;

  apb_lin_master #(.addr_width(12), .data_width(32), .timeout_cycles(16)) dut (
    .pclk(pclk), .preset_i(preset_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .timeout_o(timeout_o), .busy_o(busy_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic test_reset();
    preset_i = 1'b0; req_i = 1'b1; we_i = 1'b1; addr_i = 12'hFFF; wdata_i = 32'hFFFF_FFFF;
    prdata_i = 32'hFFFF_FFFF; pready_i = 1'b1; pslverr_i = 1'b1;
    step(); step();
    n_assert++; if ({gnt_o, rvalid_o, err_o, timeout_o, busy_o, psel_o, penable_o, pwrite_o} !== 8'h00) begin
      n_fail++; $display("FAIL rst_flags: got %b want 00000000", {gnt_o, rvalid_o, err_o, timeout_o, busy_o, psel_o, penable_o, pwrite_o}); end
    n_assert++; if (paddr_o !== 12'h000 || pwdata_o !== 32'h0 || rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_data: got paddr=%h pwdata=%h rdata=%h want 0", paddr_o, pwdata_o, rdata_o); end
    n_assert++; if (dbg_state_o !== 2'd0) begin
      n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state_o); end
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    preset_i = 1'b1;
    step();
    n_assert++; if (psel_o !== 1'b0 || gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_rst: got psel=%b gnt=%b want 0 0", psel_o, gnt_o); end
  endtask

  // Read with three wait states: pready on the fourth ACCESS cycle.
  task automatic test_read_wait();
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h0A0; wdata_i = 32'hDEAD_BEEF;
    pready_i = 1'b0; prdata_i = 32'hFFFF_0000;
    step();
    n_assert++; if (gnt_o !== 1'b1 || psel_o !== 1'b1 || penable_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL rd_setup: got gnt=%b psel=%b pen=%b busy=%b want 1 1 0 1", gnt_o, psel_o, penable_o, busy_o); end
    n_assert++; if (pwdata_o !== 32'h0 || pwrite_o !== 1'b0 || paddr_o !== 12'h0A0) begin
      n_fail++; $display("FAIL rd_capture: got pwdata=%h pwrite=%b paddr=%h want 0 0 0a0", pwdata_o, pwrite_o, paddr_o); end
    req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_assert++; if (penable_o !== 1'b1 || rvalid_o !== 1'b0 || paddr_o !== 12'h0A0) begin
        n_fail++; $display("FAIL rd_access%0d: got pen=%b rvalid=%b paddr=%h want 1 0 0a0", i, penable_o, rvalid_o, paddr_o); end
      if (i == 3) begin pready_i = 1'b1; prdata_i = 32'h0000_0055; end
    end
    step();
    n_assert++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h55 || err_o !== 1'b0 || busy_o !== 1'b0 || psel_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_done: got rvalid=%b rdata=%h err=%b busy=%b psel=%b want 1 55 0 0 0", rvalid_o, rdata_o, err_o, busy_o, psel_o); end
    pready_i = 1'b0; prdata_i = 32'hDEAD_0000;
    step();
    n_assert++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h55 || paddr_o !== 12'h0A0) begin
      n_fail++; $display("FAIL rd_hold: got rvalid=%b rdata=%h paddr=%h want 0 55 0a0", rvalid_o, rdata_o, paddr_o); end
  endtask

  task automatic test_write_zero_wait();
    req_i = 1'b1; we_i = 1'b1; addr_i = 12'h004; wdata_i = 32'hA5A5_0001;
    pready_i = 1'b1; prdata_i = 32'h1111_1111;
    step();
    n_assert++; if (gnt_o !== 1'b1 || paddr_o !== 12'h004 || pwdata_o !== 32'hA5A5_0001 || pwrite_o !== 1'b1) begin
      n_fail++; $display("FAIL wr_setup: got gnt=%b paddr=%h pwdata=%h pwrite=%b", gnt_o, paddr_o, pwdata_o, pwrite_o); end
    req_i = 1'b0;
    step();
    n_assert++; if (gnt_o !== 1'b0 || penable_o !== 1'b1 || psel_o !== 1'b1 || paddr_o !== 12'h004) begin
      n_fail++; $display("FAIL wr_access: got gnt=%b pen=%b psel=%b paddr=%h want 0 1 1 004", gnt_o, penable_o, psel_o, paddr_o); end
    step();
    n_assert++; if (rvalid_o !== 1'b1 || err_o !== 1'b0 || rdata_o !== 32'h0 || psel_o !== 1'b0 || penable_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_done: got rvalid=%b err=%b rdata=%h psel=%b pen=%b want 1 0 0 0 0", rvalid_o, err_o, rdata_o, psel_o, penable_o); end
    n_assert++; if (paddr_o !== 12'h004 || timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_paddr: got paddr=%h timeout=%b want 004 0", paddr_o, timeout_o); end
    pready_i = 1'b0;
    step();
  endtask

  task automatic test_slave_error();
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h0FC; wdata_i = '0;
    pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'hCAFE_F00D;
    step(); req_i = 1'b0;
    step();
    step();
    n_assert++; if (rvalid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0 || timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL slverr: got rvalid=%b err=%b rdata=%h timeout=%b want 1 1 0 0", rvalid_o, err_o, rdata_o, timeout_o); end
    pready_i = 1'b0; pslverr_i = 1'b0;
    step();
    n_assert++; if (err_o !== 1'b1 || rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL slverr_hold: got err=%b rvalid=%b want 1 0", err_o, rvalid_o); end
  endtask

  task automatic test_timeout();
    // Slave never answers: abort after 16 ACCESS cycles.
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h010; pready_i = 1'b0; pslverr_i = 1'b1;
    prdata_i = 32'h9999_9999;
    step(); req_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_assert++; if (penable_o !== 1'b1 || rvalid_o !== 1'b0 || timeout_o !== 1'b0) begin
        n_fail++; $display("FAIL to_wait%0d: got pen=%b rvalid=%b timeout=%b want 1 0 0", i, penable_o, rvalid_o, timeout_o); end
    end
    step();
    n_assert++; if (rvalid_o !== 1'b1 || err_o !== 1'b1 || timeout_o !== 1'b1 || rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL to_abort: got rvalid=%b err=%b timeout=%b rdata=%h want 1 1 1 0", rvalid_o, err_o, timeout_o, rdata_o); end
    n_assert++; if (psel_o !== 1'b0 || penable_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL to_drop: got psel=%b pen=%b busy=%b want 0 0 0", psel_o, penable_o, busy_o); end
    step();
    n_assert++; if (timeout_o !== 1'b0 || rvalid_o !== 1'b0 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL to_pulse: got timeout=%b rvalid=%b err=%b want 0 0 1", timeout_o, rvalid_o, err_o); end
    // pready arrives on the 16th ACCESS edge: normal completion wins.
    pslverr_i = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h014;
    step(); req_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 15) begin pready_i = 1'b1; prdata_i = 32'h1234_5678; end
    end
    step();
    n_assert++; if (rvalid_o !== 1'b1 || timeout_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'h1234_5678) begin
      n_fail++; $display("FAIL to_edge: got rvalid=%b timeout=%b err=%b rdata=%h want 1 0 0 12345678", rvalid_o, timeout_o, err_o, rdata_o); end
    pready_i = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int g1, g2, cyc;
    g1 = -1; g2 = -1; cyc = 0;
    req_i = 1'b1; we_i = 1'b1; addr_i = 12'h040; wdata_i = 32'h0000_0040; pready_i = 1'b1;
    step(); cyc++;
    if (gnt_o) g1 = cyc;
    // Second request is presented right away; it must wait for IDLE.
    addr_i = 12'h044; wdata_i = 32'h0000_0044;
    step(); cyc++;
    if (gnt_o) g2 = cyc;
    n_assert++; if (paddr_o !== 12'h040 || pwdata_o !== 32'h0000_0040) begin
      n_fail++; $display("FAIL b2b_stable: got paddr=%h pwdata=%h want 040 00000040", paddr_o, pwdata_o); end
    step(); cyc++;
    if (gnt_o) g2 = cyc;
    n_assert++; if (rvalid_o !== 1'b1 || paddr_o !== 12'h040) begin
      n_fail++; $display("FAIL b2b_first_done: got rvalid=%b paddr=%h want 1 040", rvalid_o, paddr_o); end
    step(); cyc++;
    if (gnt_o && g2 < 0) g2 = cyc;
    n_assert++; if (g1 !== 1 || g2 !== 4) begin
      n_fail++; $display("FAIL b2b_gap: got gnt cycles %0d,%0d want 1,4", g1, g2); end
    n_assert++; if (paddr_o !== 12'h044 || pwdata_o !== 32'h0000_0044) begin
      n_fail++; $display("FAIL b2b_second: got paddr=%h pwdata=%h want 044 00000044", paddr_o, pwdata_o); end
    // req pulses during SETUP and ACCESS are ignored.
    addr_i = 12'h0EE; req_i = 1'b1;
    step();
    n_assert++; if (gnt_o !== 1'b0 || penable_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ign_setup: got gnt=%b pen=%b want 0 1", gnt_o, penable_o); end
    step(); req_i = 1'b0;
    n_assert++; if (gnt_o !== 1'b0 || rvalid_o !== 1'b1 || paddr_o !== 12'h044) begin
      n_fail++; $display("FAIL b2b_ign_access: got gnt=%b rvalid=%b paddr=%h want 0 1 044", gnt_o, rvalid_o, paddr_o); end
    step();
    n_assert++; if (gnt_o !== 1'b0 || psel_o !== 1'b0 || dbg_state_o !== 2'd0) begin
      n_fail++; $display("FAIL b2b_idle: got gnt=%b psel=%b state=%0d want 0 0 0", gnt_o, psel_o, dbg_state_o); end
    pready_i = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h0C0; pready_i = 1'b0;
    step(); req_i = 1'b0;
    step(); step();
    #2 preset_i = 1'b0;
    #1;
    n_assert++; if (psel_o !== 1'b0 || penable_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got psel=%b pen=%b busy=%b want 0 0 0", psel_o, penable_o, busy_o); end
    pready_i = 1'b1; prdata_i = 32'h0000_0077;
    step();
    preset_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_assert++; if (rvalid_o !== 1'b0 || psel_o !== 1'b0) begin
        n_fail++; $display("FAIL rst_no_rvalid%0d: got rvalid=%b psel=%b want 0 0", i, rvalid_o, psel_o); end
    end
    req_i = 1'b1; addr_i = 12'h0C4;
    step(); req_i = 1'b0;
    n_assert++; if (gnt_o !== 1'b1 || paddr_o !== 12'h0C4) begin
      n_fail++; $display("FAIL rst_next_gnt: got gnt=%b paddr=%h want 1 0c4", gnt_o, paddr_o); end
    step(); step();
    n_assert++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h77 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_next_done: got rvalid=%b rdata=%h err=%b want 1 77 0", rvalid_o, rdata_o, err_o); end
    pready_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_write_zero_wait();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_lin_master.md
Name: apb_lin_master

Overview:
APB3 initiator that turns single-word requests from a local requester (LIN test sequencer / DMA-style engine) into APB transfers toward the LIN peripheral's APB slave port.
One transfer is outstanding at a time. The block captures the request, runs the APB SETUP/ACCESS phases, waits for pready, and returns read data or a completion with an error flag.
A programmable wait-state timeout ends a hung transfer with an error.

Parameters:
addr_width, 12, APB address width
data_width, 32, APB data width
timeout_cycles, 16, max consecutive ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
pclk  in  1  clock
preset_i  in  1  reset; one clock; asynchronous, active-low
req_i  in  1  request valid; sampled only in IDLE
we_i  in  1  1=write, 0=read
addr_i  in  addr_width  request address
wdata_i  in  data_width  write data
gnt_o  out  1  one-cycle pulse: request captured
rvalid_o  out  1  one-cycle pulse: transfer complete
rdata_o  out  data_width  read data, valid with rvalid_o
err_o  out  1  error flag, valid with rvalid_o
timeout_o  out  1  one-cycle pulse with rvalid_o when aborted by timeout
busy_o  out  1  high in SETUP and ACCESS
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
paddr_o  out  addr_width  APB address
pwdata_o  out  data_width  APB write data
prdata_i  in  data_width  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- All outputs are registered. FSM states: IDLE, SETUP, ACCESS.
- Reset (async, preset_i=0): state IDLE; every output 0, including paddr_o, pwdata_o and rdata_o; timeout counter 0. A reset during a transfer drops psel_o/penable_o immediately. No rvalid_o is produced for the aborted transfer.
- IDLE, rising edge with req_i=1:
  - capture addr_i into paddr_o; we_i into pwrite_o; wdata_i into pwdata_o (0 on reads).
  - next state SETUP: gnt_o=1, psel_o=1, penable_o=0, busy_o=1.
- IDLE with req_i=0: hold; psel_o=penable_o=0. paddr_o, pwrite_o and pwdata_o keep their last values.
- SETUP: exactly one cycle. gnt_o returns to 0. Next state ACCESS: penable_o=1, psel_o=1.
- ACCESS: paddr_o, pwrite_o and pwdata_o stay stable until completion.
  - Sampled pready_i=1: next cycle is IDLE with psel_o=penable_o=0 and rvalid_o=1.
  - err_o = pslverr_i.
  - rdata_o = prdata_i for a read without error; 0 for writes or on error.
  - Timeout counter clears.
- Timeout (timeout_cycles>0): counter increments on each ACCESS edge with pready_i=0. When it reaches timeout_cycles, the transfer is abandoned: next cycle IDLE, psel_o=penable_o=0, rvalid_o=1, err_o=1, timeout_o=1, rdata_o=0.
- pready_i arriving on the same edge as the timeout threshold: pready wins, normal completion, timeout_o=0.
- Outside their pulse cycle, rvalid_o/timeout_o/gnt_o are 0. err_o and rdata_o hold until the next rvalid_o.
- Back-to-back: a req_i high in the cycle rvalid_o=1 (state IDLE) is accepted on that edge.
  - Minimum transfer period: 3 cycles for a zero-wait-state slave.
- req_i/we_i/addr_i/wdata_i outside IDLE are ignored. The requester holds req_i until gnt_o if it needs the transfer.
- pslverr_i and prdata_i are ignored except on the pready_i=1 ACCESS edge.

Test Plan:
- Zero-wait write: req addr=0x004, wdata=0xA5A5_0001, slave pready=1 in first ACCESS -> gnt_o at cycle 1; SETUP cycle 1, ACCESS cycle 2; rvalid_o=1, err_o=0, rdata_o=0 at cycle 3; paddr stable 0x004 throughout.
- Read with 3 wait states: addr=0x0A0, prdata=0x0000_0055 driven with pready on 4th ACCESS cycle -> penable high 4 cycles; rvalid_o with rdata_o=0x55; busy_o low the same cycle.
- Slave error: read addr=0x0FC, pready=1 and pslverr=1 -> rvalid_o=1, err_o=1, rdata_o=0, timeout_o=0.
- Timeout: timeout_cycles=16, pready held 0 -> after 16 ACCESS cycles psel_o/penable_o drop; rvalid_o=err_o=timeout_o=1. Repeat with pready=1 on the 16th edge -> normal completion, timeout_o=0.
- Back-to-back: req_i held high for 2 writes (0x040, 0x044) with zero-wait slave -> second gnt_o exactly 3 cycles after first; no idle gap beyond the rvalid cycle. req_i pulses during SETUP/ACCESS are ignored.
- Async reset mid-ACCESS: assert preset_i=0 between edges -> psel_o/penable_o/busy_o go 0 immediately. After release, no rvalid_o; next req completes normally.
